// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the round-robin bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  localparam int DEFAULT_MAX_HOLD = 16;

endpackage

// File: rtl/bus_arbiter_round_robin_select.sv
// Combinational round-robin pick: the first set request strictly after pointer,
// wrapping, found by scanning a doubled copy of the request vector.
module round_robin_select
  import bus_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  pointer,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  id,
  output logic             any
);

  logic [2*N_REQ-1:0] w_dbl;
  logic               w_found;

  assign w_dbl = {req, req};

  // Window pointer+1 .. pointer+N_REQ of the doubled vector is one full wrap.
  always_comb begin
    w_found = 1'b0;
    gnt     = '0;
    id      = '0;
    for (int k = 0; k < 2 * N_REQ; k++) begin
      if (!w_found && (k > int'(pointer)) && (k <= int'(pointer) + N_REQ) && w_dbl[k]) begin
        w_found          = 1'b1;
        gnt[k % N_REQ]   = 1'b1;
        id               = ID_W'(k % N_REQ);
      end
    end
    any = w_found;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner for one split-transaction bus: registered one-hot grant,
// owner hold via bhold, and a sticky watchdog that breaks over-long holds.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] breq,
  input  logic [N_REQ-1:0] bhold,
  output logic [N_REQ-1:0] bgnt,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id,
  output logic             hold_timeout,
  output logic [ID_W-1:0]  timeout_id
);

  localparam int CNT_W = ($clog2(MAX_HOLD + 1) > 1) ? $clog2(MAX_HOLD + 1) : 1;

  arb_state_t       r_state, w_state_nxt;
  logic [N_REQ-1:0] r_bgnt, w_bgnt_nxt;
  // last_owner doubles as the current owner while OWNED.
  logic [ID_W-1:0]  r_last_owner, w_last_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_cnt_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic [ID_W-1:0]  r_timeout_id, w_timeout_id_nxt;

  logic [N_REQ-1:0] w_sel_gnt;
  logic [ID_W-1:0]  w_sel_id;
  logic             w_sel_any;
  logic             w_own_hold, w_keep, w_expire, w_release;

  round_robin_select #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_select (
    .req     (breq),
    .pointer (r_last_owner),
    .gnt     (w_sel_gnt),
    .id      (w_sel_id),
    .any     (w_sel_any)
  );

  assign w_own_hold = bhold[r_last_owner];
  assign w_keep     = w_own_hold && ((MAX_HOLD == 0) || (r_hold_cnt < CNT_W'(MAX_HOLD)));
  assign w_expire   = w_own_hold && (MAX_HOLD != 0) && (r_hold_cnt == CNT_W'(MAX_HOLD));

  always_comb begin
    w_state_nxt      = r_state;
    w_bgnt_nxt       = r_bgnt;
    w_last_nxt       = r_last_owner;
    w_cnt_nxt        = r_hold_cnt;
    w_timeout_nxt    = r_timeout;
    w_timeout_id_nxt = r_timeout_id;
    w_release        = 1'b0;

    case (r_state)
      ARB_IDLE: w_release = 1'b1;
      ARB_OWNED: begin
        if (w_keep) begin
          if (r_hold_cnt != '1) w_cnt_nxt = r_hold_cnt + 1'b1;
        end else begin
          w_release = 1'b1;
          if (w_expire) begin
            w_timeout_nxt = 1'b1;
            if (!r_timeout) w_timeout_id_nxt = r_last_owner;
          end
        end
      end
      default: w_release = 1'b1;
    endcase

    // Hand-over in the same edge; previous owner is searched last.
    if (w_release) begin
      if (w_sel_any) begin
        w_state_nxt = ARB_OWNED;
        w_bgnt_nxt  = w_sel_gnt;
        w_last_nxt  = w_sel_id;
        w_cnt_nxt   = CNT_W'(1);
      end else begin
        w_state_nxt = ARB_IDLE;
        w_bgnt_nxt  = '0;
        w_cnt_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ARB_IDLE;
      r_bgnt       <= '0;
      r_last_owner <= ID_W'(N_REQ - 1);
      r_hold_cnt   <= '0;
      r_timeout    <= 1'b0;
      r_timeout_id <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_bgnt       <= w_bgnt_nxt;
      r_last_owner <= w_last_nxt;
      r_hold_cnt   <= w_cnt_nxt;
      r_timeout    <= w_timeout_nxt;
      r_timeout_id <= w_timeout_id_nxt;
    end
  end

  assign bgnt         = r_bgnt;
  assign grant_valid  = |r_bgnt;
  assign grant_id     = (|r_bgnt) ? r_last_owner : '0;
  assign hold_timeout = r_timeout;
  assign timeout_id   = r_timeout_id;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with N_REQ=4, MAX_HOLD=4.
module tb_bus_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] breq;
  logic [3:0] bhold;
  logic [3:0] bgnt;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       hold_timeout;
  logic [1:0] timeout_id;

  int checks   = 0;
  int failures = 0;

  bus_arbiter #(
    .N_REQ    (4),
    .MAX_HOLD (4),
    .ID_W     (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .breq         (breq),
    .bhold        (bhold),
    .bgnt         (bgnt),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .hold_timeout (hold_timeout),
    .timeout_id   (timeout_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    breq  = 4'b0000;
    bhold = 4'b0000;
    tick();
    tick();
    chk("reset_bgnt", 32'(bgnt), 32'h0);
    chk("reset_valid", 32'(grant_valid), 32'h0);
    chk("reset_id", 32'(grant_id), 32'h0);
    chk("reset_timeout", 32'(hold_timeout), 32'h0);
    chk("reset_timeout_id", 32'(timeout_id), 32'h0);
    reset = 1'b0;

    // Idle with no requests
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_bgnt_valid_id", {25'h0, bgnt, grant_valid, grant_id}, 32'h0);
    end

    // All requesting, none holding: rotation 0,1,2,3,0
    breq = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rotate_bgnt", 32'(bgnt), 32'(4'b0001 << (i % 4)));
      chk("rotate_id", 32'(grant_id), 32'(i % 4));
    end
    breq = 4'b0000;
    tick();
    chk("rotate_to_idle", 32'(bgnt), 32'h0);
    chk("rotate_to_idle_valid", 32'(grant_valid), 32'h0);

    // Requester 2 alone, holds cycles 1-2, releases in cycle 3
    breq = 4'b0100;
    tick();
    chk("r2_cycle1", 32'(bgnt), 32'h4);
    chk("r2_cycle1_id", 32'(grant_id), 32'h2);
    bhold = 4'b0100;
    tick();
    chk("r2_cycle2", 32'(bgnt), 32'h4);
    breq = 4'b0101;
    tick();
    chk("r2_cycle3", 32'(bgnt), 32'h4);
    bhold = 4'b0000;
    breq  = 4'b0001;
    tick();
    chk("r2_handover_to_0", 32'(bgnt), 32'h1);
    chk("r2_handover_id", 32'(grant_id), 32'h0);

    // Non-owner bhold ignored
    bhold = 4'b1000;
    breq  = 4'b0010;
    tick();
    chk("nonowner_hold_moves", 32'(bgnt), 32'h2);
    chk("nonowner_no_timeout", 32'(hold_timeout), 32'h0);
    bhold = 4'b0000;
    breq  = 4'b0000;
    tick();
    chk("idle_again", 32'(bgnt), 32'h0);

    // Watchdog: requester 1 holds forever, requester 3 waiting
    breq  = 4'b0010;
    bhold = 4'b0010;
    tick();
    chk("wd_hold_c1", 32'(bgnt), 32'h2);
    breq = 4'b1010;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("wd_hold_cn", 32'(bgnt), 32'h2);
      chk("wd_no_timeout_yet", 32'(hold_timeout), 32'h0);
    end
    tick();
    chk("wd_release_to_3", 32'(bgnt), 32'h8);
    chk("wd_timeout_set", 32'(hold_timeout), 32'h1);
    chk("wd_timeout_id", 32'(timeout_id), 32'h1);

    // Later traffic leaves the sticky flag; second timeout keeps first id
    breq  = 4'b0001;
    bhold = 4'b0000;
    tick();
    chk("post_wd_grant0", 32'(bgnt), 32'h1);
    chk("post_wd_sticky", 32'(hold_timeout), 32'h1);
    bhold = 4'b0001;
    for (int i = 0; i < 3; i++) tick();
    chk("r0_still_holding", 32'(bgnt), 32'h1);
    tick();
    chk("r0_regrant_after_timeout", 32'(bgnt), 32'h1);
    chk("second_timeout_sticky", 32'(hold_timeout), 32'h1);
    chk("second_timeout_keeps_id", 32'(timeout_id), 32'h1);

    // Reset mid-grant
    bhold = 4'b0100;
    breq  = 4'b0100;
    tick();
    chk("pre_reset_owner2", 32'(bgnt), 32'h4);
    reset = 1'b1;
    tick();
    chk("midgrant_reset_bgnt", 32'(bgnt), 32'h0);
    chk("midgrant_reset_valid", 32'(grant_valid), 32'h0);
    chk("midgrant_reset_timeout", 32'(hold_timeout), 32'h0);
    chk("midgrant_reset_timeout_id", 32'(timeout_id), 32'h0);
    reset = 1'b0;
    bhold = 4'b0000;
    breq  = 4'b0110;
    tick();
    chk("post_reset_first_grant", 32'(bgnt), 32'h2);
    chk("post_reset_first_id", 32'(grant_id), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
